// File: rtl/b2_rr_arb_3_1_pkg.sv
// Shared types and constants for the 3:1 round-robin arbiter.
package b2_arb_pkg;

  localparam int N_REQ = 3;

  typedef logic [1:0] idx_t;

  localparam idx_t REQ0 = 2'd0;
  localparam idx_t REQ1 = 2'd1;
  localparam idx_t REQ2 = 2'd2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Modulo-3 increment; the unused code 3 folds onto REQ0.
  function automatic idx_t wrap_inc(input idx_t i);
    return (i >= REQ2) ? REQ0 : idx_t'(i + 2'd1);
  endfunction

endpackage

// File: rtl/b2_rr_arb_3_1_if.sv
// Requester/sink bundle of the arbiter; slave is the arbiter side.
interface b2_rr_arb_3_1_if;
  import b2_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [1:0]       d0;
  logic [1:0]       d1;
  logic [1:0]       d2;
  logic [N_REQ-1:0] ack;
  logic [1:0]       y;
  logic             y_valid;
  logic             y_ready;
  idx_t             sel;

  modport master (
    output req, d0, d1, d2, y_ready,
    input  ack, y, y_valid, sel
  );

  modport slave (
    input  req, d0, d1, d2, y_ready,
    output ack, y, y_valid, sel
  );

endinterface

// File: rtl/b2_rr_arb_3_1_pick.sv
// Rotate-and-priority picker: searches last+1, last+2, last (mod 3).
module b2_rr_pick_3
  import b2_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             last,
  output idx_t             g,
  output logic             any
);

  idx_t p0;
  idx_t p1;
  idx_t p2;

  always_comb begin
    p0  = wrap_inc(last);
    p1  = wrap_inc(p0);
    p2  = wrap_inc(p1);
    any = |req;
    g   = p0;
    if (req[p0])      g = p0;
    else if (req[p1]) g = p1;
    else if (req[p2]) g = p2;
  end

endmodule

// File: rtl/b2_rr_arb_3_1.sv
// Round-robin 3:1 arbiter with a single registered 2-bit output stage.
//   state    | meaning
//   ST_EMPTY | y holds no unconsumed word (y_valid=0)
//   ST_FULL  | y holds a word waiting for y_ready (y_valid=1)
module b2_rr_arb_3_1
  import b2_arb_pkg::*;
#(
  parameter idx_t RESET_LAST = 2'd2
) (
  input logic            clk,
  input logic            rst_n,
  b2_rr_arb_3_1_if.slave bus
);

  state_t           state;
  idx_t             last;
  idx_t             sel_q;
  logic [1:0]       y_q;
  idx_t             g;
  logic             any;
  logic             load;
  logic [1:0]       mux_d;
  logic [N_REQ-1:0] ack_c;

  b2_rr_pick_3 u_pick (
    .req  (bus.req),
    .last (last),
    .g    (g),
    .any  (any)
  );

  assign load = any && ((state == ST_EMPTY) || bus.y_ready);

  // Gated by rst_n so no requester sees a grant while reset is held.
  always_comb begin
    ack_c = '0;
    if (load && rst_n) ack_c[g] = 1'b1;
  end

  always_comb begin
    case (g)
      REQ0:    mux_d = bus.d0;
      REQ1:    mux_d = bus.d1;
      REQ2:    mux_d = bus.d2;
      default: mux_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      y_q   <= 2'b00;
      sel_q <= REQ0;
      last  <= RESET_LAST;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load) begin
            y_q   <= mux_d;
            sel_q <= g;
            last  <= g;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (load) begin
            y_q   <= mux_d;
            sel_q <= g;
            last  <= g;
          end else if (bus.y_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.ack     = ack_c;
  assign bus.y       = y_q;
  assign bus.y_valid = (state == ST_FULL);
  assign bus.sel     = sel_q;

endmodule

// File: tb/tb_b2_rr_arb_3_1.sv
// Bench for b2_rr_arb_3_1: directed vector table, reset cases and random traffic vs. a reference model.
module tb_b2_rr_arb_3_1;
  import b2_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  b2_rr_arb_3_1_if bus ();

  b2_rr_arb_3_1 #(.RESET_LAST(2'd2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] req;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] d2;
    logic       rdy;
    logic [2:0] exp_ack;
    logic [1:0] exp_y;
    logic       exp_valid;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  int m_last  = 2;
  int m_y     = 0;
  int m_sel   = 0;
  int m_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requester found scanning last+1, last+2, last+3 (mod 3).
  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = 2;
    m_y     = 0;
    m_sel   = 0;
    m_valid = 0;
  endtask

  // Drive one cycle of stimulus, check ack before the edge and outputs after it.
  task automatic apply(input logic [2:0] r, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic rdy, output logic [2:0] ack_s);
    int g;
    int ld;
    bus.req     = r;
    bus.d0      = a;
    bus.d1      = b;
    bus.d2      = c;
    bus.y_ready = rdy;
    #1;
    g  = pick(r, m_last);
    ld = (g >= 0 && (m_valid == 0 || rdy)) ? 1 : 0;
    ack_s = bus.ack;
    chk("model_ack", int'(bus.ack), (ld != 0) ? (1 << g) : 0);
    @(posedge clk);
    #1;
    if (ld != 0) begin
      m_y     = (g == 0) ? int'(a) : (g == 1) ? int'(b) : int'(c);
      m_sel   = g;
      m_last  = g;
      m_valid = 1;
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
    chk("model_y",       int'(bus.y),       m_y);
    chk("model_y_valid", int'(bus.y_valid), m_valid);
    chk("model_sel",     int'(bus.sel),     m_sel);
  endtask

  initial begin
    logic [2:0] ack_s;

    // req, d0, d1, d2, rdy | ack, y, y_valid, sel
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b0, 3'b001, 2'd1, 1'b1, 2'd0});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b010, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b100, 2'd3, 1'b1, 2'd2});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b001, 2'd1, 1'b1, 2'd0});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b010, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b100, 2'd3, 1'b1, 2'd2});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b001, 2'd1, 1'b1, 2'd0});
    tbl.push_back(vec_t'{3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 3'b010, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b110, 2'd1, 2'd2, 2'd3, 1'b0, 3'b000, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b110, 2'd1, 2'd2, 2'd3, 1'b0, 3'b000, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b110, 2'd1, 2'd2, 2'd3, 1'b0, 3'b000, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b110, 2'd1, 2'd2, 2'd3, 1'b0, 3'b000, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b110, 2'd1, 2'd2, 2'd3, 1'b1, 3'b100, 2'd3, 1'b1, 2'd2});
    tbl.push_back(vec_t'{3'b100, 2'd0, 2'd0, 2'd3, 1'b1, 3'b100, 2'd3, 1'b1, 2'd2});
    tbl.push_back(vec_t'{3'b100, 2'd0, 2'd0, 2'd3, 1'b1, 3'b100, 2'd3, 1'b1, 2'd2});
    tbl.push_back(vec_t'{3'b100, 2'd0, 2'd0, 2'd3, 1'b1, 3'b100, 2'd3, 1'b1, 2'd2});
    tbl.push_back(vec_t'{3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 3'b000, 2'd3, 1'b0, 2'd2});
    tbl.push_back(vec_t'{3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000, 2'd3, 1'b0, 2'd2});
    tbl.push_back(vec_t'{3'b010, 2'd0, 2'd2, 2'd0, 1'b1, 3'b010, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b011, 2'd1, 2'd2, 2'd0, 1'b1, 3'b001, 2'd1, 1'b1, 2'd0});
    tbl.push_back(vec_t'{3'b011, 2'd1, 2'd2, 2'd0, 1'b1, 3'b010, 2'd2, 1'b1, 2'd1});
    tbl.push_back(vec_t'{3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 3'b000, 2'd2, 1'b0, 2'd1});

    bus.req     = 3'b111;
    bus.d0      = 2'd1;
    bus.d1      = 2'd2;
    bus.d2      = 2'd3;
    bus.y_ready = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_y_valid", int'(bus.y_valid), 0);
    chk("rst_ack",     int'(bus.ack),     0);
    chk("rst_y",       int'(bus.y),       0);
    chk("rst_sel",     int'(bus.sel),     0);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy, ack_s);
      chk($sformatf("tbl%0d_ack", i),     int'(ack_s),         int'(tbl[i].exp_ack));
      chk($sformatf("tbl%0d_y", i),       int'(bus.y),         int'(tbl[i].exp_y));
      chk($sformatf("tbl%0d_y_valid", i), int'(bus.y_valid),   int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_sel", i),     int'(bus.sel),       int'(tbl[i].exp_sel));
    end

    // Reset while FULL: word dropped asynchronously, priority restarts at requester 0.
    apply(3'b010, 2'd0, 2'd1, 2'd0, 1'b0, ack_s);
    chk("pre_rst_full", int'(bus.y_valid), 1);
    #2;
    bus.req     = 3'b111;
    bus.y_ready = 1'b1;
    rst_n       = 1'b0;
    #1;
    chk("midrst_y_valid", int'(bus.y_valid), 0);
    chk("midrst_ack",     int'(bus.ack),     0);
    chk("midrst_y",       int'(bus.y),       0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(3'b111, 2'd2, 2'd1, 2'd3, 1'b1, ack_s);
    chk("restart_ack", int'(ack_s), 3'b001);
    chk("restart_y",   int'(bus.y), 2);

    for (int n = 0; n < 400; n++) begin
      apply(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0), ack_s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b2_rr_arb_3_1.md
# b2_rr_arb_3_1

Round-robin arbiter that shares one 2-bit 3:1 data multiplexer among three requesters and registers the winner into a single output stage. Each requester offers 2-bit data with a valid/ready handshake (`req`/`ack`). The arbiter picks the winner, drives the mux select, and holds the captured word until the downstream consumer accepts it. It sits between three producer blocks and one shared 2-bit sink.

## Interface
- `RESET_LAST`, default 2'd2: value of the last-grant pointer after reset. With the default, requester 0 has highest priority first.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 3: `req[i]` means requester i offers valid data on `d<i>`.
- `d0`, `d1`, `d2` input 2 each: requester data.
- `ack` output 3: `ack[i]` means requester i's word is captured at this edge. Combinational, at most one bit set.
- `y` output 2: registered output word.
- `y_valid` output 1: `y` holds an unconsumed word.
- `y_ready` input 1: sink accepts `y` when `y_valid && y_ready` at a clock edge.
- `sel` output 2: index of the requester whose word is in `y`. Registered; 2'b11 is never driven.

## Operation
- Two states, encoded by `y_valid`:
  - EMPTY (`y_valid`=0).
  - FULL (`y_valid`=1).
- `load = |req && (!y_valid || y_ready)`.
- Grant `g` is chosen combinationally from `req` and the pointer `last`:
  - Search order is `last+1`, `last+2`, `last` (all mod 3).
  - The first set `req` bit wins.
  - Wrap-around: with `last`=2 the order is 0, 1, 2.
- `ack[g] = load`. All other `ack` bits are 0.
- On an edge with `load`=1: `y <= d<g>`, `sel <= g`, `last <= g`, `y_valid <= 1`.
- On an edge with `load`=0 and `y_valid && y_ready`: `y_valid <= 0`. `y`, `sel` and `last` hold.
- Otherwise all registers hold.
- FULL and `y_ready`=0: `ack`=0. `y` and `sel` are stable, and requesters keep `req` and data stable.
- Simultaneous consume and load: a new word replaces the consumed one in the same edge. `y_valid` stays 1, giving one word per cycle.
- A single persistent requester is granted every cycle the stage can load. No starvation: with all three requesting continuously, grants rotate 0, 1, 2, 0, …
- `req` dropping without `ack` is allowed. That request is simply not granted.
- Reset values: `y`=2'b00, `y_valid`=0, `sel`=2'b00, `last`=`RESET_LAST`. While `rst_n`=0, `ack`=3'b000.
- Reset asserted mid-operation: the word held in `y` is discarded. No `ack` is issued during reset.

## Timing
- Latency: `req[i] && ack[i]` at edge k gives `y_valid`=1 with that data from k until it is consumed.
- Throughput: 1 word/cycle when `y_ready` is held at 1.
- Combinational paths:
  - `req` → `ack`.
  - `y_ready` → `ack`.
  - No path from `req` or `d*` to `y`, `y_valid` or `sel` (registered).
- First cycle after `rst_n` deasserts: the arbiter may load immediately if `req` is nonzero.

## Structure
- Package `b2_arb_pkg` holds:
  - `N_REQ`=3.
  - Index localparams `REQ0`/`REQ1`/`REQ2`.
  - The 2-bit index type used for `g`, `sel` and `last`.
- Sub-module `b2_rr_pick_3`: combinational rotate-and-priority picker. Takes `req[2:0]` and `last[1:0]`; produces `g[1:0]` and `any`.
- The data path is the existing 2-bit 3:1 case mux with a `default` branch. It takes `sel` = `g` and feeds the `y` register.

## Test plan
- Reset with `req`=3'b111 and `y_ready`=0: `y_valid`=0, `ack`=0, `y`=0. The first edge after release loads requester 0; `ack`=3'b001.
- `req`=3'b111 held, `y_ready`=1, `d0`=1, `d1`=2, `d2`=3: `sel` sequence is 0,1,2,0,1,2 and `y` sequence is 1,2,3,1,2,3, one per cycle, `y_valid` constantly 1.
- `y_ready`=0 for 4 cycles while FULL with `y`=2, `req`=3'b110: `ack`=0, and `y` and `sel` hold. When `y_ready` goes to 1, the next word loads on that same edge.
- Only `req[2]` active, `d2`=3, `y_ready`=1: granted every cycle, `sel`=2, `y`=3, `ack`=3'b100 each cycle.
- Assert `rst_n`=0 while FULL: `y_valid` goes to 0 asynchronously and `ack`=0. After release, priority restarts at requester 0.
- `last`=1 and `req`=3'b011: requester 0 wins (wrap-around), then requester 1 on the next load.
